// File: rtl/legv8_ctrl_pkg.sv
// legv8_ctrl_pkg: shared types and constants for the LEGv8 multicycle controller.
// Holds the FSM state enum, the instruction-class enum, opcode constants,
// alu_op encodings, and the IMMOP_* immediate-generator select codes.
package legv8_ctrl_pkg;

  // Instruction word width (bus width).
  localparam int INSTRSIZE = 32;

  // Immediate-generator select codes.
  localparam logic [4:0] IMMOP_I     = 5'd0;
  localparam logic [4:0] IMMOP_D     = 5'd1;
  localparam logic [4:0] IMMOP_B     = 5'd2;
  localparam logic [4:0] IMMOP_CB    = 5'd3;
  localparam logic [4:0] IMMOP_SHIFT = 5'd4;

  // ALU operation encodings.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_LSL = 2'b10;
  localparam logic [1:0] ALU_LSR = 2'b11;

  // Opcode fields, matched against the top bits of the instruction.
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU   = 3'd0,
    CL_B     = 3'd1,
    CL_CBZ   = 3'd2,
    CL_CBNZ  = 3'd3,
    CL_LOAD  = 3'd4,
    CL_STORE = 3'd5
  } class_e;

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// legv8_multicycle_ctrl_if: shared instruction/data memory port.
// Handshake: the controller raises mem_req (with mem_we / mem_addr_sel) and
// holds it unchanged until the memory answers with mem_ready=1 in the same
// cycle; that cycle completes the access. Only reset may drop mem_req early.
interface legv8_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/legv8_ctrl_decode.sv
// legv8_ctrl_decode: combinational opcode decoder.
// Maps the instruction opcode to class, imm_op, alu_op, alu_src_imm and an
// illegal flag for opcodes outside the supported set.
module legv8_ctrl_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [INSTRSIZE-1:0] instr,
  output class_e               cls,
  output logic [4:0]           imm_op,
  output logic [1:0]           alu_op,
  output logic                 alu_src_imm,
  output logic                 illegal
);

  // Low instruction bits carry register/immediate fields, not opcode.
  logic unused_fields;
  assign unused_fields = ^instr[20:0];

  // Priority-free opcode match: each encoding is unique in its field width.
  always_comb begin
    cls         = CL_ALU;
    imm_op      = IMMOP_I;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    illegal     = 1'b0;
    if (instr[31:21] == OP_LDUR) begin
      cls = CL_LOAD;  imm_op = IMMOP_D; alu_src_imm = 1'b1;
    end else if (instr[31:21] == OP_STUR) begin
      cls = CL_STORE; imm_op = IMMOP_D; alu_src_imm = 1'b1;
    end else if (instr[31:21] == OP_LSL) begin
      imm_op = IMMOP_SHIFT; alu_op = ALU_LSL; alu_src_imm = 1'b1;
    end else if (instr[31:21] == OP_LSR) begin
      imm_op = IMMOP_SHIFT; alu_op = ALU_LSR; alu_src_imm = 1'b1;
    end else if (instr[31:21] == OP_ADD) begin
      alu_op = ALU_ADD;
    end else if (instr[31:21] == OP_SUB) begin
      alu_op = ALU_SUB;
    end else if (instr[31:22] == OP_ADDI) begin
      alu_op = ALU_ADD; alu_src_imm = 1'b1;
    end else if (instr[31:22] == OP_SUBI) begin
      alu_op = ALU_SUB; alu_src_imm = 1'b1;
    end else if (instr[31:24] == OP_CBZ) begin
      cls = CL_CBZ;  imm_op = IMMOP_CB;
    end else if (instr[31:24] == OP_CBNZ) begin
      cls = CL_CBNZ; imm_op = IMMOP_CB;
    end else if (instr[31:26] == OP_B) begin
      cls = CL_B;    imm_op = IMMOP_B;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl: multicycle FETCH/DECODE/EXEC/MEM/WB control FSM.
// Optional retired-instruction counter enabled by macro LEGV8_CTRL_RETIRE_EN;
// without it, `retired` is tied to zero.
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INSTRSIZE-1:0]  instr,
  input  logic                  alu_zero,
  legv8_multicycle_ctrl_if.master bus,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  pc_sel,
  output logic [4:0]            imm_op,
  output logic                  alu_src_imm,
  output logic [1:0]            alu_op,
  output logic                  reg_we,
  output logic                  wb_sel,
  output logic                  instr_done,
  output logic                  illegal,
  output logic [RETIRE_W-1:0]   retired,
  output state_e                dbg_state
);

  state_e     state_q, state_d;
  class_e     cls_q, cls_d;
  logic [4:0] imm_op_q, imm_op_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic       alu_src_imm_q, alu_src_imm_d;

  class_e     dec_cls;
  logic [4:0] dec_imm_op;
  logic [1:0] dec_alu_op;
  logic       dec_alu_src_imm;
  logic       dec_illegal;

  logic mem_req, mem_we, mem_addr_sel;

  legv8_ctrl_decode u_decode (
    .instr       (instr),
    .cls         (dec_cls),
    .imm_op      (dec_imm_op),
    .alu_op      (dec_alu_op),
    .alu_src_imm (dec_alu_src_imm),
    .illegal     (dec_illegal)
  );

  // State and decoded-field registers; reset returns to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      cls_q         <= CL_ALU;
      imm_op_q      <= IMMOP_I;
      alu_op_q      <= ALU_ADD;
      alu_src_imm_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      imm_op_q      <= imm_op_d;
      alu_op_q      <= alu_op_d;
      alu_src_imm_q <= alu_src_imm_d;
    end
  end

  // Next state and strobes; strobes are forced low while reset is held.
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    imm_op_d      = imm_op_q;
    alu_op_d      = alu_op_q;
    alu_src_imm_d = alu_src_imm_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 1'b0;
    reg_we        = 1'b0;
    wb_sel        = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        cls_d         = dec_cls;
        imm_op_d      = dec_imm_op;
        alu_op_d      = dec_alu_op;
        alu_src_imm_d = dec_alu_src_imm;
        if (dec_illegal) begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CL_B: begin
            pc_we = 1'b1; pc_sel = 1'b1; instr_done = 1'b1; state_d = ST_FETCH;
          end
          CL_CBZ: begin
            pc_we = alu_zero; pc_sel = alu_zero; instr_done = 1'b1; state_d = ST_FETCH;
          end
          CL_CBNZ: begin
            pc_we = ~alu_zero; pc_sel = ~alu_zero; instr_done = 1'b1; state_d = ST_FETCH;
          end
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == CL_STORE);
        if (bus.mem_ready) begin
          if (cls_q == CL_STORE) begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_we     = 1'b1;
        wb_sel     = (cls_q == CL_LOAD);
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    if (rst) begin
      mem_req = 1'b0; mem_we = 1'b0; mem_addr_sel = 1'b0;
      ir_we = 1'b0; pc_we = 1'b0; pc_sel = 1'b0;
      reg_we = 1'b0; wb_sel = 1'b0; instr_done = 1'b0; illegal = 1'b0;
    end
  end

  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr_sel = mem_addr_sel;
  assign imm_op           = imm_op_q;
  assign alu_op           = alu_op_q;
  assign alu_src_imm      = alu_src_imm_q;
  assign dbg_state        = state_q;

`ifdef LEGV8_CTRL_RETIRE_EN
  logic [RETIRE_W-1:0] retired_q, retired_d;

  // Retired count advances once per instr_done pulse and wraps.
  always_comb begin
    retired_d = retired_q;
    if (instr_done) retired_d = retired_q + RETIRE_W'(1);
  end

  // Retired counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) retired_q <= '0;
    else     retired_q <= retired_d;
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule
